wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//   MEM/WB pipeline register plus writeback logic of the 5-stage RV32I pipeline.
//   Captures the retiring instruction from MEM and extracts/sign-extends load data.
//   Selects the result and drives Wt_addr/Wt_data/RegWrite straight into the register file.
//   Keeps the 64-bit retired-instruction counter (instret) used by the VGA debug view.
// PARAMETERS
//   XLEN       32  datapath width; the RV32 pipeline uses only 32
//   INSTRET_W  64  width of the retired-instruction counter
// PORTS
//   clk            in   1     pipeline clock, rising edge
//   rst            in   1     asynchronous reset, ACTIVE-LOW (rst==0 resets)
//   stall          in   1     hold the WB register (from hazard unit)
//   flush          in   1     load a bubble into the WB register
//   in_valid       in   1     MEM stage carries a real instruction
//   in_pc          in   XLEN  PC of the MEM-stage instruction
//   in_alu_result  in   XLEN  ALU result / effective address
//   in_mem_rdata   in   XLEN  word-aligned data-memory read data
//   in_imm         in   XLEN  U-type immediate (LUI)
//   in_rd          in   5     destination register
//   in_reg_write   in   1     instruction writes rd
//   in_wb_sel      in   2     00 ALU, 01 load, 10 PC+4, 11 imm
//   in_funct3      in   3     load width/sign (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu)
//   Wt_addr        out  5     register-file write address
//   Wt_data        out  XLEN  register-file write data
//   RegWrite       out  1     register-file write enable
//   wb_valid       out  1     WB stage holds a real instruction
//   wb_pc          out  XLEN  PC of the WB-stage instruction
//   instret        out  INSTRET_W  count of retired instructions
// BEHAVIOUR
// - Reset (rst==0, async): valid=0, all stage fields=0, instret=0, so RegWrite=0,
//   Wt_addr=0, Wt_data=0, wb_valid=0, wb_pc=0 immediately. Reset mid-stall/mid-write
//   drops the held instruction; no write occurs until the next capture after release.
// - Rising clk, priority: flush > stall > capture.
//   flush: valid<=0; other fields don't-care (held). stall: every field holds.
//   Otherwise all in_* fields are captured. Latency MEM->WB = 1 cycle.
// - Outputs are combinational from the registered fields (no extra cycle):
//   RegWrite = valid & reg_write & (rd!=0); Wt_addr = rd when RegWrite, else 0.
//   Under stall, RegWrite stays asserted each held cycle (rewrites same value; harmless).
// - Wt_data by wb_sel: 00 alu_result; 01 load_data; 10 pc+4 (mod 2^32); 11 imm.
// - load_data, lane = alu_result[1:0]:
//   lb/lbu: byte at bits [8*lane+7:8*lane], sign-/zero-extend.
//   lh/lhu: halfword selected by alu_result[1] (bit 0 ignored), sign-/zero-extend.
//   lw: full word (offset ignored). Any other funct3: load_data=0.
// - instret += 1 on a rising edge when valid==1 && stall==0 (instruction leaves WB),
//   including when flush is also asserted on that edge. Bubbles never count.
//   Wraps 2^INSTRET_W-1 -> 0 silently.
// - in_reg_write with in_rd==0 is captured and counted but never writes.
// TESTING
// 1 Reset: drive rst=0 mid-run with valid ALU write -> RegWrite=0, instret=0 same cycle.
// 2 ALU write: rd=5, wb_sel=00, alu=0x1234 -> next cycle Wt_addr=5, Wt_data=0x1234, RegWrite=1; instret+1.
// 3 Loads: rdata=0x80F0_7F01; lb@addr..2 -> 0xFFFFFFF0; lbu@..2 -> 0x000000F0;
//   lh@..2 -> 0xFFFF80F0; lhu@..0 -> 0x00007F01; lw -> 0x80F07F01.
// 4 Stall 3 cycles on rd=7 write -> RegWrite held 3 cycles, instret +1 only after release.
// 5 Flush with stall both high -> bubble: wb_valid=0, RegWrite=0, no instret increment.
// 6 rd=0 write, JAL pc=0xFFFF_FFFC wb_sel=10 -> RegWrite=0; with rd=1 -> Wt_data=0x0.

Source files
------------

// File: rtl/wb_stage_if.sv
// MEM->WB bus: the retiring instruction entering the stage and the writeback/debug view leaving it.
interface wb_stage_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned INSTRET_W = 64
);
  logic                 in_valid;
  logic [XLEN-1:0]      in_pc;
  logic [XLEN-1:0]      in_alu_result;
  logic [XLEN-1:0]      in_mem_rdata;
  logic [XLEN-1:0]      in_imm;
  logic [4:0]           in_rd;
  logic                 in_reg_write;
  logic [1:0]           in_wb_sel;
  logic [2:0]           in_funct3;

  logic [4:0]           Wt_addr;
  logic [XLEN-1:0]      Wt_data;
  logic                 RegWrite;
  logic                 wb_valid;
  logic [XLEN-1:0]      wb_pc;
  logic [INSTRET_W-1:0] instret;

  modport master (
    output in_valid, in_pc, in_alu_result, in_mem_rdata, in_imm,
           in_rd, in_reg_write, in_wb_sel, in_funct3,
    input  Wt_addr, Wt_data, RegWrite, wb_valid, wb_pc, instret
  );

  modport slave (
    input  in_valid, in_pc, in_alu_result, in_mem_rdata, in_imm,
           in_rd, in_reg_write, in_wb_sel, in_funct3,
    output Wt_addr, Wt_data, RegWrite, wb_valid, wb_pc, instret
  );
endinterface

// File: rtl/wb_stage.sv
// MEM/WB pipeline register with load extraction, result select and register-file write port.
// Also keeps the retired-instruction counter shown on the debug view.
module wb_stage #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned INSTRET_W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  wb_stage_if.slave    bus
);

  localparam int unsigned RD_W  = 5;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned F3_W  = 3;

  localparam logic [SEL_W-1:0] SEL_ALU  = 2'b00;
  localparam logic [SEL_W-1:0] SEL_LOAD = 2'b01;
  localparam logic [SEL_W-1:0] SEL_PC4  = 2'b10;

  localparam logic [F3_W-1:0] F3_LB  = 3'b000;
  localparam logic [F3_W-1:0] F3_LH  = 3'b001;
  localparam logic [F3_W-1:0] F3_LW  = 3'b010;
  localparam logic [F3_W-1:0] F3_LBU = 3'b100;
  localparam logic [F3_W-1:0] F3_LHU = 3'b101;

  logic                 valid_q,     valid_d;
  logic [XLEN-1:0]      pc_q,        pc_d;
  logic [XLEN-1:0]      alu_q,       alu_d;
  logic [XLEN-1:0]      rdata_q,     rdata_d;
  logic [XLEN-1:0]      imm_q,       imm_d;
  logic [RD_W-1:0]      rd_q,        rd_d;
  logic                 reg_write_q, reg_write_d;
  logic [SEL_W-1:0]     wb_sel_q,    wb_sel_d;
  logic [F3_W-1:0]      funct3_q,    funct3_d;
  logic [INSTRET_W-1:0] instret_q,   instret_d;

  logic [7:0]           byte_sel;
  logic [15:0]          half_sel;
  logic [XLEN-1:0]      load_data;
  logic [XLEN-1:0]      result;
  logic                 we;

  // Next-state: flush beats stall beats capture; a held valid instruction retires on any non-stalled edge.
  always_comb begin
    valid_d     = valid_q;
    pc_d        = pc_q;
    alu_d       = alu_q;
    rdata_d     = rdata_q;
    imm_d       = imm_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    wb_sel_d    = wb_sel_q;
    funct3_d    = funct3_q;
    instret_d   = instret_q + INSTRET_W'(valid_q & ~stall);

    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d     = bus.in_valid;
      pc_d        = bus.in_pc;
      alu_d       = bus.in_alu_result;
      rdata_d     = bus.in_mem_rdata;
      imm_d       = bus.in_imm;
      rd_d        = bus.in_rd;
      reg_write_d = bus.in_reg_write;
      wb_sel_d    = bus.in_wb_sel;
      funct3_d    = bus.in_funct3;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      alu_q       <= '0;
      rdata_q     <= '0;
      imm_q       <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      wb_sel_q    <= '0;
      funct3_q    <= '0;
      instret_q   <= '0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      alu_q       <= alu_d;
      rdata_q     <= rdata_d;
      imm_q       <= imm_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      wb_sel_q    <= wb_sel_d;
      funct3_q    <= funct3_d;
      instret_q   <= instret_d;
    end
  end

  // Lane extraction from the word-aligned read data; halfwords ignore address bit 0.
  always_comb begin
    byte_sel  = 8'h00;
    half_sel  = 16'h0000;
    load_data = '0;

    case (alu_q[1:0])
      2'd0:    byte_sel = rdata_q[7:0];
      2'd1:    byte_sel = rdata_q[15:8];
      2'd2:    byte_sel = rdata_q[23:16];
      default: byte_sel = rdata_q[31:24];
    endcase

    half_sel = alu_q[1] ? rdata_q[31:16] : rdata_q[15:0];

    case (funct3_q)
      F3_LB:   load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  load_data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  load_data = {{(XLEN-16){1'b0}}, half_sel};
      F3_LW:   load_data = rdata_q;
      default: load_data = '0;
    endcase
  end

  always_comb begin
    result = imm_q;
    case (wb_sel_q)
      SEL_ALU:  result = alu_q;
      SEL_LOAD: result = load_data;
      SEL_PC4:  result = pc_q + XLEN'(4);
      default:  result = imm_q;
    endcase
  end

  // x0 is hardwired, so a write to rd 0 is suppressed here rather than in the register file.
  assign we = valid_q & reg_write_q & (rd_q != RD_W'(0));

  assign bus.RegWrite = we;
  assign bus.Wt_addr  = we ? rd_q : RD_W'(0);
  assign bus.Wt_data  = result;
  assign bus.wb_valid = valid_q;
  assign bus.wb_pc    = pc_q;
  assign bus.instret  = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: vector table through a scoreboard queue, plus stall/flush/reset/wrap sequences.
module tb_wb_stage;

  logic clk;
  logic rst;
  logic stall;
  logic flush;

  wb_stage_if #(.XLEN(32), .INSTRET_W(64)) bus ();
  wb_stage_if #(.XLEN(32), .INSTRET_W(4))  bus4 ();

  wb_stage #(.XLEN(32), .INSTRET_W(64)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .bus(bus.slave)
  );

  // Narrow-counter copy sees identical stimulus, used for the wrap check.
  wb_stage #(.XLEN(32), .INSTRET_W(4)) dut4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .bus(bus4.slave)
  );

  assign bus4.in_valid      = bus.in_valid;
  assign bus4.in_pc         = bus.in_pc;
  assign bus4.in_alu_result = bus.in_alu_result;
  assign bus4.in_mem_rdata  = bus.in_mem_rdata;
  assign bus4.in_imm        = bus.in_imm;
  assign bus4.in_rd         = bus.in_rd;
  assign bus4.in_reg_write  = bus.in_reg_write;
  assign bus4.in_wb_sel     = bus.in_wb_sel;
  assign bus4.in_funct3     = bus.in_funct3;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_we;
  } vec_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        we;
    logic        valid;
    logic [31:0] pc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  int n_chk  = 0;
  int n_pass = 0;
  logic        m_valid = 1'b0;
  longint unsigned cnt = 0;
  longint unsigned saved;

  localparam logic [31:0] R = 32'h80F0_7F01;

  function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                              input logic [31:0] rdata, input logic [31:0] imm, input logic [4:0] rd,
                              input logic rw, input logic [1:0] sel, input logic [2:0] f3,
                              input logic [4:0] ea, input logic [31:0] ed, input logic ew);
    vec_t t;
    t.v = v; t.pc = pc; t.alu = alu; t.rdata = rdata; t.imm = imm; t.rd = rd;
    t.rw = rw; t.sel = sel; t.f3 = f3; t.e_addr = ea; t.e_data = ed; t.e_we = ew;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
  endtask

  task automatic drive(input vec_t t);
    bus.in_valid      = t.v;
    bus.in_pc         = t.pc;
    bus.in_alu_result = t.alu;
    bus.in_mem_rdata  = t.rdata;
    bus.in_imm        = t.imm;
    bus.in_rd         = t.rd;
    bus.in_reg_write  = t.rw;
    bus.in_wb_sel     = t.sel;
    bus.in_funct3     = t.f3;
  endtask

  task automatic push_exp(input vec_t t);
    exp_t e;
    e.addr = t.e_addr; e.data = t.e_data; e.we = t.e_we; e.valid = t.v; e.pc = t.pc;
    sb.push_back(e);
  endtask

  // One clock edge plus the reference occupancy/retire model; returns 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    if (m_valid && !stall) cnt++;
    if (flush) m_valid = 1'b0;
    else if (!stall) m_valid = bus.in_valid;
    #1;
  endtask

  task automatic check_sb(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      chk({nm, "_sb_empty"}, 64'(1), 64'(0));
      return;
    end
    e = sb.pop_front();
    chk({nm, "_addr"},    64'(bus.Wt_addr),  64'(e.addr));
    chk({nm, "_data"},    64'(bus.Wt_data),  64'(e.data));
    chk({nm, "_we"},      64'(bus.RegWrite), 64'(e.we));
    chk({nm, "_valid"},   64'(bus.wb_valid), 64'(e.valid));
    chk({nm, "_pc"},      64'(bus.wb_pc),    64'(e.pc));
    chk({nm, "_instret"}, bus.instret,       cnt);
  endtask

  task automatic run_one(input vec_t t, input string nm);
    drive(t);
    push_exp(t);
    step();
    check_sb(nm);
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    vecs.push_back(mk(1, 32'h100, 32'h1234, 0, 0, 5, 1, 2'b00, 3'b000, 5, 32'h0000_1234, 1));
    vecs.push_back(mk(1, 32'h104, 32'h1002, R, 0, 10, 1, 2'b01, 3'b000, 10, 32'hFFFF_FFF0, 1));
    vecs.push_back(mk(1, 32'h108, 32'h1002, R, 0, 10, 1, 2'b01, 3'b100, 10, 32'h0000_00F0, 1));
    vecs.push_back(mk(1, 32'h10C, 32'h1002, R, 0, 11, 1, 2'b01, 3'b001, 11, 32'hFFFF_80F0, 1));
    vecs.push_back(mk(1, 32'h110, 32'h1000, R, 0, 12, 1, 2'b01, 3'b101, 12, 32'h0000_7F01, 1));
    vecs.push_back(mk(1, 32'h114, 32'h1003, R, 0, 13, 1, 2'b01, 3'b010, 13, 32'h80F0_7F01, 1));
    vecs.push_back(mk(1, 32'h118, 32'h1000, R, 0, 14, 1, 2'b01, 3'b000, 14, 32'h0000_0001, 1));
    vecs.push_back(mk(1, 32'h11C, 32'h1003, R, 0, 14, 1, 2'b01, 3'b000, 14, 32'hFFFF_FF80, 1));
    vecs.push_back(mk(1, 32'h120, 32'h1001, R, 0, 15, 1, 2'b01, 3'b100, 15, 32'h0000_007F, 1));
    vecs.push_back(mk(1, 32'h124, 32'h1003, R, 0, 16, 1, 2'b01, 3'b001, 16, 32'hFFFF_80F0, 1));
    vecs.push_back(mk(1, 32'h128, 32'h1001, R, 0, 17, 1, 2'b01, 3'b101, 17, 32'h0000_7F01, 1));
    vecs.push_back(mk(1, 32'h12C, 32'h1000, R, 0, 18, 1, 2'b01, 3'b001, 18, 32'h0000_7F01, 1));
    vecs.push_back(mk(1, 32'h130, 32'h1000, R, 0, 19, 1, 2'b01, 3'b011, 19, 32'h0000_0000, 1));
    vecs.push_back(mk(1, 32'h134, 32'h1000, R, 0, 19, 1, 2'b01, 3'b111, 19, 32'h0000_0000, 1));
    vecs.push_back(mk(1, 32'h138, 0, 0, 32'hABCD_E000, 3, 1, 2'b11, 0, 3, 32'hABCD_E000, 1));
    vecs.push_back(mk(1, 32'h100, 0, 0, 0, 1, 1, 2'b10, 0, 1, 32'h0000_0104, 1));
    vecs.push_back(mk(1, 32'hFFFF_FFFC, 0, 0, 0, 0, 1, 2'b10, 0, 0, 32'h0000_0000, 0));
    vecs.push_back(mk(1, 32'hFFFF_FFFC, 0, 0, 0, 1, 1, 2'b10, 0, 1, 32'h0000_0000, 1));
    vecs.push_back(mk(0, 32'h140, 32'h55, 0, 0, 4, 1, 2'b00, 0, 0, 32'h0000_0055, 0));
    vecs.push_back(mk(1, 32'h144, 32'h66, 0, 0, 6, 0, 2'b00, 0, 0, 32'h0000_0066, 0));
    vecs.push_back(mk(1, 32'h148, 32'hFFFF_FFFF, 0, 0, 31, 1, 2'b00, 0, 31, 32'hFFFF_FFFF, 1));

    // Reset values while held in reset.
    #12;
    chk("rst_we",      64'(bus.RegWrite), 64'(0));
    chk("rst_addr",    64'(bus.Wt_addr),  64'(0));
    chk("rst_data",    64'(bus.Wt_data),  64'(0));
    chk("rst_valid",   64'(bus.wb_valid), 64'(0));
    chk("rst_pc",      64'(bus.wb_pc),    64'(0));
    chk("rst_instret", bus.instret,       64'(0));
    rst = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_one(vecs[i], $sformatf("vec%0d", i));

    // Stall: rd=7 write held for three edges, retires only on release.
    run_one(mk(1, 32'h200, 32'h7777, 0, 0, 7, 1, 2'b00, 0, 7, 32'h7777, 1), "stall_cap");
    saved = cnt;
    stall = 1'b1;
    drive(mk(1, 32'h204, 32'h9999, 0, 0, 9, 1, 2'b00, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("stall%0d_we", k),      64'(bus.RegWrite), 64'(1));
      chk($sformatf("stall%0d_addr", k),    64'(bus.Wt_addr),  64'(7));
      chk($sformatf("stall%0d_data", k),    64'(bus.Wt_data),  64'(32'h7777));
      chk($sformatf("stall%0d_instret", k), bus.instret,       saved);
    end
    stall = 1'b0;
    bus.in_valid = 1'b0;
    step();
    chk("stall_rel_instret", bus.instret, saved + 1);
    chk("stall_rel_valid",   64'(bus.wb_valid), 64'(0));

    // Flush together with stall: bubble, no retire.
    run_one(mk(1, 32'h300, 32'h8888, 0, 0, 8, 1, 2'b00, 0, 8, 32'h8888, 1), "fs_cap");
    saved = cnt;
    stall = 1'b1; flush = 1'b1;
    step();
    chk("fs_valid",   64'(bus.wb_valid), 64'(0));
    chk("fs_we",      64'(bus.RegWrite), 64'(0));
    chk("fs_addr",    64'(bus.Wt_addr),  64'(0));
    chk("fs_instret", bus.instret,       saved);
    stall = 1'b0; flush = 1'b0;
    step();
    chk("fs_bubble_instret", bus.instret, saved);

    // Flush alone: the leaving instruction still counts.
    run_one(mk(1, 32'h304, 32'h8889, 0, 0, 8, 1, 2'b00, 0, 8, 32'h8889, 1), "fl_cap");
    saved = cnt;
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_valid",   64'(bus.wb_valid), 64'(0));
    chk("fl_instret", bus.instret,       saved + 1);

    // Narrow counter wraps silently (well past 16 retirements by now).
    chk("wrap_cnt_gt16", 64'(cnt > 16), 64'(1));
    chk("wrap_instret4", 64'(bus4.instret), 64'(cnt[3:0]));

    // Reset mid-write drops the held instruction at once.
    run_one(mk(1, 32'h400, 32'h4444, 0, 0, 5, 1, 2'b00, 0, 5, 32'h4444, 1), "mr_cap");
    #2 rst = 1'b0;
    #1;
    chk("mr_we",       64'(bus.RegWrite), 64'(0));
    chk("mr_addr",     64'(bus.Wt_addr),  64'(0));
    chk("mr_data",     64'(bus.Wt_data),  64'(0));
    chk("mr_valid",    64'(bus.wb_valid), 64'(0));
    chk("mr_pc",       64'(bus.wb_pc),    64'(0));
    chk("mr_instret",  bus.instret,       64'(0));
    chk("mr_instret4", 64'(bus4.instret), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    m_valid = 1'b0; cnt = 0;
    chk("mr_rel_we", 64'(bus.RegWrite), 64'(0));
    run_one(mk(1, 32'h400, 32'h4444, 0, 0, 5, 1, 2'b00, 0, 5, 32'h4444, 1), "mr_recap");
    bus.in_valid = 1'b0;
    step();
    chk("mr_post_instret", bus.instret, 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
